// File: rtl/led_pwm_blink_driver.sv
// LED output stage: global PWM brightness, optional blink gating and
// optional polarity inversion applied to the PIO LED pattern.
// Configured via a small Avalon-MM slave with a zero-wait combinational read.
module led_pwm_blink_driver #(
  parameter int TICK_DIV = 50000,
  parameter int NUM_LEDS = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
  localparam logic [1:0]  ADDR_DUTY   = 2'd0;
  localparam logic [1:0]  ADDR_HALF   = 2'd1;
  localparam logic [1:0]  ADDR_CTRL   = 2'd2;
  localparam logic [1:0]  ADDR_STATUS = 2'd3;

  // Configuration registers
  logic [7:0]          duty_reg;
  logic [15:0]         blink_half_reg;
  logic                blink_en_reg;
  logic                invert_reg;

  // Timing state
  logic [15:0]         tick_cnt_reg;
  logic [15:0]         tick_cnt_next;
  logic                tick;
  logic [7:0]          pwm_cnt_reg;
  logic [15:0]         blink_cnt_reg;
  logic [15:0]         blink_cnt_next;
  logic                phase_reg;
  logic                phase_next;

  // Datapath
  logic                wr_en;
  logic                blink_restart;
  logic                pwm_on;
  logic                gate;
  logic [NUM_LEDS-1:0] led_next;
  logic [NUM_LEDS-1:0] led_out_reg;

  // Only the low 16 data bits are ever stored.
  logic                unused_writedata;
  assign unused_writedata = ^writedata[31:16];

  assign wr_en = chipselect && !write_n;

  // Restart the blink sequence on any BLINK_HALF write or a 0->1 blink_en write.
  assign blink_restart = wr_en &&
                         ((address == ADDR_HALF) ||
                          ((address == ADDR_CTRL) && writedata[0] && !blink_en_reg));

  // Register file writes; STATUS is read-only so writes to it fall through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_reg       <= 8'hFF;
      blink_half_reg <= 16'd0;
      blink_en_reg   <= 1'b0;
      invert_reg     <= 1'b0;
    end else if (wr_en) begin
      case (address)
        ADDR_DUTY: duty_reg       <= writedata[7:0];
        ADDR_HALF: blink_half_reg <= writedata[15:0];
        ADDR_CTRL: begin
          blink_en_reg <= writedata[0];
          invert_reg   <= writedata[1];
        end
        default: ;
      endcase
    end
  end

  // Free-running tick prescaler, 0..TICK_DIV-1.
  always_comb begin
    tick          = (tick_cnt_reg == TICK_LAST);
    tick_cnt_next = tick ? 16'd0 : tick_cnt_reg + 16'd1;
  end

  // Prescaler and PWM counters are only cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_reg <= 16'd0;
      pwm_cnt_reg  <= 8'd0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      pwm_cnt_reg  <= pwm_cnt_reg + 8'd1;
    end
  end

  // Blink half-period counter; restart beats a coincident tick.
  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (blink_restart || (blink_half_reg == 16'd0)) begin
      blink_cnt_next = 16'd0;
      phase_next     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg == blink_half_reg - 16'd1) begin
        blink_cnt_next = 16'd0;
        phase_next     = !phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 16'd1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg <= 16'd0;
      phase_reg     <= 1'b1;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  // Full duty is special-cased so 0xFF has no off slot at pwm_cnt 255.
  always_comb begin
    pwm_on = (duty_reg == 8'hFF) || (pwm_cnt_reg < duty_reg);
    gate   = pwm_on && (phase_reg || !blink_en_reg);
  end

  // Per-LED gating and polarity.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    assign led_next[gi] = (led_in[gi] & gate) ^ invert_reg;
  end

  // Registered LED pin drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out_reg <= '0;
    end else begin
      led_out_reg <= led_next;
    end
  end

  assign led_out = led_out_reg;

  // Zero-wait read mux, zero-extended to 32 bits.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DUTY:   readdata[7:0]  = duty_reg;
      ADDR_HALF:   readdata[15:0] = blink_half_reg;
      ADDR_CTRL:   readdata[1:0]  = {invert_reg, blink_en_reg};
      ADDR_STATUS: readdata[NUM_LEDS:0] = {led_out_reg, phase_reg};
      default:     readdata = 32'd0;
    endcase
  end

endmodule

// File: doc/led_pwm_blink_driver.md
Name: led_pwm_blink_driver

Overview:
- Output stage placed directly downstream of the 9-bit green-LED PIO.
- Consumes the PIO's 9-bit out_port and drives the physical LEDR/LEDG pins.
- Applies global PWM brightness, optional blink gating and optional polarity inversion.
- Configured by software through its own small Avalon-MM slave: 2-bit word address, zero-wait combinational read.

Parameters:
- TICK_DIV, 50000, clk cycles per blink tick (1 ms at 50 MHz); legal range 2..65535.
- NUM_LEDS, 9, width of LED input/output vectors; legal range 1..16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- led_in  input  NUM_LEDS  LED pattern from upstream PIO out_port.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, combinational from address.
- led_out  output  NUM_LEDS  registered drive to LED pins.

Behaviour:
- Reset and clocking: one clock (clk); reset_n is asynchronous, active-low.
- Register map (write when chipselect && !write_n):
  - addr 0 DUTY[7:0], reset 0xFF.
  - addr 1 BLINK_HALF[15:0], half-period in ticks, reset 0.
  - addr 2 CTRL: bit0 blink_en, bit1 invert; reset 0.
  - addr 3 STATUS, read-only; writes ignored.
- Readdata: zero-extended to 32 bits.
  - STATUS = {phase at bit0, led_out at bits NUM_LEDS:1}.
  - Unused bits read 0.
- Tick prescaler:
  - 16-bit counter counts 0..TICK_DIV-1, free-running; wraps to 0.
  - tick is a 1-cycle pulse when the counter equals TICK_DIV-1.
- PWM:
  - 8-bit pwm_cnt increments every clk and wraps 255->0.
  - pwm_on = (DUTY==0xFF) || (pwm_cnt < DUTY).
  - DUTY=0 gives always off; DUTY=0xFF gives always on, with no 1/256 gap.
- Blink:
  - 16-bit blink_cnt advances only on tick.
  - When blink_cnt == BLINK_HALF-1 on a tick: blink_cnt<=0 and phase toggles.
  - BLINK_HALF==0: counter held at 0, phase held 1.
- Blink restart: any write to BLINK_HALF, or a CTRL write that sets blink_en from 0 to 1, forces blink_cnt<=0 and phase<=1 on that edge.
  - This restart has priority over a coincident tick.
- gate = pwm_on && (phase || !blink_en).
- Output: led_out <= (led_in & {NUM_LEDS{gate}}) ^ {NUM_LEDS{invert}}.
  - Latency is 1 clk from led_in or any config change.
  - Reset value of led_out is all 0.
- Register-write timing: new DUTY/CTRL values take effect in the led_out computed on the edge after the write edge.
  - No glitch beyond that one-cycle step.
- Prescaler and pwm_cnt are not reset by register writes; only by reset_n.
- Reset asserted mid-operation: all counters, phase, registers and led_out clear/return to reset values immediately, without waiting for clk.
  - On deassertion, operation restarts at tick count 0 and pwm_cnt 0.
- led_in is assumed synchronous to clk; no synchronizer.

Test Plan:
- Reset, then led_in=0x1A5 with defaults -> led_out=0x1A5 one clk later; STATUS reads 0x34B (phase=1, led_out<<1).
- DUTY=0x40, led_in=0x1FF -> over 256 clk, led_out==0x1FF on exactly 64 cycles (pwm_cnt 0..63), 0 otherwise; DUTY=0 -> led_out constantly 0.
- TICK_DIV=4, BLINK_HALF=3, CTRL=1, DUTY=0xFF, led_in=0x0F0 -> led_out alternates 0x0F0 / 0x000, each for 12 clk, starting with the on phase after the CTRL write.
- CTRL=3 (blink + invert) during an off phase -> led_out=0x1FF; clear blink_en -> led_out=0x10F (0x0F0 ^ 0x1FF) one clk later.
- Write BLINK_HALF coincident with a phase-toggling tick -> phase=1 and blink_cnt=0 the next cycle; toggle is suppressed.
- Assert reset_n low asynchronously mid-blink with led_out=0x0F0 -> led_out=0 before the next clk edge; DUTY reads 0xFF after release.
